// File: rtl/led_sequencer.sv
// Eight-LED sequencer: off / static / blink / bouncing chase, stepped by a prescaler.
// Optional LED_PWM_EN adds a per-command 4-bit duty gate on lit LEDs.
module led_sequencer #(
   parameter int STEP_DIV   = 1200000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_mode,
   input  logic [7:0] cmd_pattern,
`ifdef LED_PWM_EN
   input  logic [3:0] cmd_duty,
`endif
   output logic       step_tick,
   output logic       D1,
   output logic       D2,
   output logic       D3,
   output logic       D4,
   output logic       D5,
   output logic       D6,
   output logic       D7,
   output logic       D8
);

   localparam int PW = $clog2(STEP_DIV);

   // Mode states share the cmd_mode encoding so LOAD can jump straight to them.
   localparam logic [2:0] S_OFF    = 3'd0;
   localparam logic [2:0] S_STATIC = 3'd1;
   localparam logic [2:0] S_BLINK  = 3'd2;
   localparam logic [2:0] S_CHASE  = 3'd3;
   localparam logic [2:0] S_LOAD   = 3'd4;

   logic [2:0]    state;
   logic [1:0]    mode_q;
   logic [7:0]    pat_q;
   logic [PW-1:0] presc;
   logic [2:0]    pos;
   logic          dir_dn;
   logic          phase_off;
   logic [7:0]    led_q;
   logic [7:0]    frame;
   logic [7:0]    lit;
   logic          wrap;
   logic          accept;

   assign cmd_ready = (state != S_LOAD);
   assign accept    = cmd_valid && cmd_ready;
   assign wrap      = (presc == PW'(STEP_DIV - 1));

   always_comb begin
      frame = '0;
      case (state)
         S_STATIC: frame = pat_q;
         S_BLINK:  frame = phase_off ? 8'h00 : pat_q;
         S_CHASE:  frame = 8'd1 << pos;
         default:  frame = '0;
      endcase
   end

`ifdef LED_PWM_EN
   logic [3:0] duty_q;
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk) begin
      if (rst) pwm_cnt <= '0;
      else     pwm_cnt <= pwm_cnt + 4'd1;
   end

   assign lit = frame & {8{pwm_cnt <= duty_q}};
`else
   assign lit = frame;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_OFF;
         mode_q    <= '0;
         pat_q     <= '0;
         presc     <= '0;
         pos       <= '0;
         dir_dn    <= 1'b0;
         phase_off <= 1'b0;
         step_tick <= 1'b0;
         led_q     <= '0;
`ifdef LED_PWM_EN
         duty_q    <= 4'hF;
`endif
      end else if (state == S_LOAD) begin
         // LED frame is held here so the new mode's first frame lands cleanly.
         presc     <= '0;
         pos       <= '0;
         dir_dn    <= 1'b0;
         phase_off <= 1'b0;
         step_tick <= 1'b0;
         state     <= {1'b0, mode_q};
      end else begin
         presc     <= wrap ? '0 : presc + PW'(1);
         step_tick <= wrap;
         led_q     <= lit;
         if (wrap && state == S_BLINK) phase_off <= ~phase_off;
         if (wrap && state == S_CHASE) begin
            if (!dir_dn) begin
               if (pos == 3'd7) begin
                  dir_dn <= 1'b1;
                  pos    <= 3'd6;
               end else begin
                  pos <= pos + 3'd1;
               end
            end else begin
               if (pos == 3'd0) begin
                  dir_dn <= 1'b0;
                  pos    <= 3'd1;
               end else begin
                  pos <= pos - 3'd1;
               end
            end
         end
         if (accept) begin
            state  <= S_LOAD;
            mode_q <= cmd_mode;
            pat_q  <= cmd_pattern;
`ifdef LED_PWM_EN
            duty_q <= cmd_duty;
`endif
         end
      end
   end

   logic [7:0] d_vec;
   assign d_vec = led_q ^ {8{ACTIVE_LOW}};
   assign {D8, D7, D6, D5, D4, D3, D2, D1} = d_vec;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer (STEP_DIV=4): step-count reference model plus directed and random scenarios.
module tb_led_sequencer;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_mode = 2'b00;
   logic [7:0] cmd_pattern = 8'h00;
   logic       cmd_ready, step_tick, al_ready, al_tick;
   logic       d1, d2, d3, d4, d5, d6, d7, d8;
   logic       a1, a2, a3, a4, a5, a6, a7, a8;
   logic [7:0] dvec, avec;

   assign dvec = {d8, d7, d6, d5, d4, d3, d2, d1};
   assign avec = {a8, a7, a6, a5, a4, a3, a2, a1};

   always #5 clk = ~clk;

   led_sequencer #(.STEP_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_pattern(cmd_pattern),
`ifdef LED_PWM_EN
      .cmd_duty(4'hF),
`endif
      .step_tick(step_tick),
      .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5), .D6(d6), .D7(d7), .D8(d8));

   led_sequencer #(.STEP_DIV(SD), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(al_ready),
      .cmd_mode(cmd_mode), .cmd_pattern(cmd_pattern),
`ifdef LED_PWM_EN
      .cmd_duty(4'hF),
`endif
      .step_tick(al_tick),
      .D1(a1), .D2(a2), .D3(a3), .D4(a4), .D5(a5), .D6(a6), .D7(a7), .D8(a8));

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: m_st 0..3 = mode, 4 = load; m_j counts cycles spent in the mode.
   int         m_st = 0;
   int         m_j = 0;
   logic [1:0] m_mode = 2'b00;
   logic [7:0] m_pat = 8'h00;
   logic [7:0] m_led = 8'h00;
   logic       m_tick = 1'b0;
   logic       m_ready = 1'b1;

   function automatic logic [7:0] model_frame(int st, logic [7:0] pat, int step);
      int p;
      case (st)
         1: return pat;
         2: return (step % 2 == 0) ? pat : 8'h00;
         3: begin
            p = step % 14;
            if (p > 7) p = 14 - p;
            return 8'd1 << p;
         end
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic v, input logic [1:0] m, input logic [7:0] p);
      if (r) begin
         m_st = 0; m_j = 0; m_led = 8'h00; m_tick = 1'b0;
      end else if (m_st == 4) begin
         m_st = int'(m_mode); m_j = 0; m_tick = 1'b0;
      end else begin
         m_led  = model_frame(m_st, m_pat, m_j / SD);
         m_tick = ((m_j + 1) % SD == 0);
         m_j++;
         if (v) begin
            m_st = 4; m_mode = m; m_pat = p;
         end
      end
      m_ready = (m_st != 4);
   endtask

   task automatic step_cyc(input logic r, input logic v, input logic [1:0] m, input logic [7:0] p);
      rst = r; cmd_valid = v; cmd_mode = m; cmd_pattern = p;
      @(posedge clk);
      model_edge(r, v, m, p);
      @(negedge clk);
   endtask

   task automatic test_reset;
      int ticks;
      for (int i = 0; i < 3; i++) begin
         step_cyc(1'b1, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if ({dvec, cmd_ready, step_tick} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got led=%h rdy=%b tick=%b want led=00 rdy=1 tick=0", dvec, cmd_ready, step_tick);
         end
      end
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         ticks += int'(step_tick);
         n_chk++;
         if ({dvec, cmd_ready, step_tick} !== {m_led, m_ready, m_tick}) begin
            n_fail++;
            $display("FAIL off_idle: got %h/%b/%b want %h/%b/%b", dvec, cmd_ready, step_tick, m_led, m_ready, m_tick);
         end
      end
      n_chk++;
      if (ticks != 3) begin
         n_fail++;
         $display("FAIL off_tick_count: got %0d want 3", ticks);
      end
   endtask

   task automatic test_active_low;
      step_cyc(1'b1, 1'b0, 2'b00, 8'h00);
      n_chk++;
      if (avec !== 8'hFF) begin
         n_fail++;
         $display("FAIL al_reset: got %h want ff", avec);
      end
      step_cyc(1'b0, 1'b1, 2'b01, 8'h3C);
      for (int i = 0; i < 8; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if (avec !== ~m_led) begin
            n_fail++;
            $display("FAIL al_static: got %h want %h", avec, ~m_led);
         end
      end
   endtask

   task automatic test_static;
      step_cyc(1'b1, 1'b0, 2'b00, 8'h00);
      step_cyc(1'b0, 1'b1, 2'b01, 8'hA5);
      n_chk++;
      if (cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL static_load_ready: got %b want 0", cmd_ready);
      end
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      n_chk++;
      if ({cmd_ready, dvec} !== {1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL static_hold: got rdy=%b led=%h want rdy=1 led=00", cmd_ready, dvec);
      end
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      n_chk++;
      if (dvec !== 8'hA5) begin
         n_fail++;
         $display("FAIL static_latency: got %h want a5", dvec);
      end
      for (int i = 0; i < 20 * SD; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if ({dvec, cmd_ready, step_tick} !== {m_led, m_ready, m_tick}) begin
            n_fail++;
            $display("FAIL static_stable: got %h/%b/%b want %h/%b/%b", dvec, cmd_ready, step_tick, m_led, m_ready, m_tick);
         end
      end
   endtask

   task automatic test_chase;
      logic [7:0] prev;
      step_cyc(1'b0, 1'b1, 2'b11, 8'hFF);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      n_chk++;
      if (dvec !== 8'h01) begin
         n_fail++;
         $display("FAIL chase_first: got %h want 01", dvec);
      end
      prev = dvec;
      for (int i = 0; i < 18 * SD; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if ({dvec, cmd_ready, step_tick} !== {m_led, m_ready, m_tick}) begin
            n_fail++;
            $display("FAIL chase_seq: got %h/%b/%b want %h/%b/%b", dvec, cmd_ready, step_tick, m_led, m_ready, m_tick);
         end
         // At each step boundary the lit LED must have moved.
         if (i % SD == SD - 1) begin
            n_chk++;
            if (dvec === prev || $countones(dvec) != 1) begin
               n_fail++;
               $display("FAIL chase_move: got %h prev %h", dvec, prev);
            end
            prev = dvec;
         end
      end
   endtask

   task automatic test_blink;
      step_cyc(1'b0, 1'b1, 2'b10, 8'h0F);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      for (int i = 0; i < 6 * SD; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if (dvec !== (((i / SD) % 2 == 0) ? 8'h0F : 8'h00)) begin
            n_fail++;
            $display("FAIL blink_0f: cycle %0d got %h", i, dvec);
         end
      end
      step_cyc(1'b0, 1'b1, 2'b10, 8'h00);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      for (int i = 0; i < 6 * SD; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if ({dvec, step_tick} !== {8'h00, m_tick}) begin
            n_fail++;
            $display("FAIL blink_zero: got %h/%b want 00/%b", dvec, step_tick, m_tick);
         end
      end
   endtask

   task automatic test_restart;
      step_cyc(1'b0, 1'b1, 2'b11, 8'h00);
      for (int i = 0; i < 2 + 5 * SD; i++) step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      n_chk++;
      if (dvec !== 8'h20) begin
         n_fail++;
         $display("FAIL restart_pos5: got %h want 20", dvec);
      end
      step_cyc(1'b0, 1'b1, 2'b11, 8'h00);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      for (int i = 0; i < SD + 1; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if (dvec !== ((i < SD) ? 8'h01 : 8'h02)) begin
            n_fail++;
            $display("FAIL restart_dwell: cycle %0d got %h", i, dvec);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] rdy;
      for (int i = 0; i < 3; i++) begin
         step_cyc(1'b0, 1'b1, 2'b01, 8'(8'h11 << i));
         rdy[i] = cmd_ready;
      end
      n_chk++;
      if (rdy !== 3'b010) begin
         n_fail++;
         $display("FAIL b2b_ready: got %b want 010", rdy);
      end
      for (int i = 0; i < 4; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if ({dvec, cmd_ready, step_tick} !== {m_led, m_ready, m_tick}) begin
            n_fail++;
            $display("FAIL b2b_model: got %h/%b/%b want %h/%b/%b", dvec, cmd_ready, step_tick, m_led, m_ready, m_tick);
         end
      end
      n_chk++;
      if (dvec !== 8'h44) begin
         n_fail++;
         $display("FAIL b2b_pattern: got %h want 44", dvec);
      end
   endtask

   task automatic test_mid_reset;
      step_cyc(1'b0, 1'b1, 2'b10, 8'h0F);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
      step_cyc(1'b1, 1'b1, 2'b01, 8'hFF);
      n_chk++;
      if ({dvec, cmd_ready, step_tick} !== {8'h00, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_state: got %h/%b/%b want 00/1/0", dvec, cmd_ready, step_tick);
      end
      for (int i = 0; i < 3 * SD; i++) begin
         step_cyc(1'b0, 1'b0, 2'b00, 8'h00);
         n_chk++;
         if ({dvec, cmd_ready} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_off: got %h/%b want 00/1", dvec, cmd_ready);
         end
      end
   endtask

   task automatic test_random;
      logic r, v;
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 99) == 0);
         v = ($urandom_range(0, 11) == 0);
         step_cyc(r, v, 2'($urandom_range(0, 3)), 8'($urandom));
         n_chk++;
         if ({dvec, cmd_ready, step_tick} !== {m_led, m_ready, m_tick}) begin
            n_fail++;
            $display("FAIL random: cycle %0d got %h/%b/%b want %h/%b/%b", i, dvec, cmd_ready, step_tick, m_led, m_ready, m_tick);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_active_low();
      test_static();
      test_chase();
      test_blink();
      test_restart();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
